// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO, runtime parity and stop-bit selection
//
// Purpose:
//   Queues words written from the bus side and serialises them LSB first onto tx.
//   Frames go out back-to-back while the FIFO holds data. The external baud generator
//   supplies one baud_tick per bit period.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            transmitter enable; low aborts the frame in flight (FIFO kept)
//   baud_tick         one-cycle pulse per bit period
//   parity_mode       00 none, 01 even, 10 odd, 11 none; latched at frame start
//   two_stop          1 selects two stop bits; latched at frame start
//   flush             empties the FIFO (wins over a same-cycle push)
//   wr_data/wr_valid  push port; wr_ready = !full
//   overflow          one-cycle pulse after a push attempt while full
//   fifo_count        queued entries, excluding the frame in flight
//   tx                serial line, idle high, registered
//   busy, done        FSM not idle / one-cycle pulse at end of each frame
//   dbg_tx_state      current FSM state encoding
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 baud_tick,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 flush,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 overflow,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_tx_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BC_W  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, push, pop;

  // Transmit FSM state and frame-local copies of the configuration
  state_t               state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] pop_data;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = wr_valid && !full && !flush;
  // A pop only happens from IDLE, so a freshly pushed entry is seen one cycle later.
  assign pop      = (state_q == S_IDLE) && enable && !empty;
  assign pop_data = fifo_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = wr_valid && full;
    if (flush) begin
      // The popped word (if any) is already captured by the FSM this edge.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    if (!enable) begin
      state_d = S_IDLE;
      tx_d    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (pop) begin
            shift_d    = pop_data;
            par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d  = (^pop_data) ^ (parity_mode == 2'b10);
            two_stop_d = two_stop;
            tx_d       = 1'b0;
            state_d    = S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            tx_d      = shift_q[0];
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
              stop_cnt_d = 1'b0;
              if (par_en_q) begin
                tx_d    = par_bit_q;
                state_d = S_PARITY;
              end else begin
                tx_d    = 1'b1;
                state_d = S_STOP;
              end
            end else begin
              // shift_q[0] is on the line; bit 1 becomes the next one.
              tx_d      = shift_q[1];
              shift_d   = shift_q >> 1;
              bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (!two_stop_q || stop_cnt_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
        S_DONE: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign wr_ready     = !full;
  assign overflow     = ovf_q;
  assign fifo_count   = count_q;
  assign tx           = tx_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign dbg_tx_state = state_q;

endmodule
